fphub_mult_issuer: RTL and testbench
====================================

FPHUB_MULT_ISSUER -- requirements
Module: fphub_mult_issuer

Interface
REQ-001 Parameter FpFormat, default fpnew_pkg::FP16, is the operand format.
REQ-002 Parameter WIDTH, default fpnew_pkg::fp_width(FpFormat), is the operand/result width.
REQ-003 Parameter DEPTH, default 4 (power of two, >=2), is the result FIFO depth and the maximum number of operations in flight.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1/1  host command handshake.
REQ-007 cmd_a_i, cmd_b_i  in  WIDTH each  multiplicand and multiplier, HUB format.
REQ-008 flush_i  in  1  host abort request.
REQ-009 clear_flags_i  in  1  clears the sticky flags.
REQ-010 operands_o  out  [2:0][WIDTH-1:0]  to the multiply unit; [1]=A, [2]=B, [0]=0.
REQ-011 op_o  out  fpnew_pkg::operation_e  constant fpnew_pkg::MUL; op_mod_o  out  1  constant 0.
REQ-012 in_valid_o / in_ready_i  out/in  1/1  request handshake to the unit.
REQ-013 flush_o  out  1  flush to the unit.
REQ-014 result_i  in  WIDTH, status_i  in  fpnew_pkg::status_t, out_valid_i / out_ready_o  in/out  1/1  unit response channel.
REQ-015 rsp_valid_o / rsp_ready_i  out/in  1/1, rsp_result_o  out  WIDTH, rsp_status_o  out  fpnew_pkg::status_t  host response channel.
REQ-016 fflags_o  out  fpnew_pkg::status_t  sticky OR of captured status; done_cnt_o  out  16  completed-result count.

Function
REQ-017 FSM states: IDLE (nothing held or outstanding), RUN (command held, operations outstanding, or FIFO non-empty), FLUSH (one cycle).
REQ-018 IDLE->RUN on command accept; RUN->IDLE when holding register, outstanding count and FIFO are all empty; any state->FLUSH on flush_i; FLUSH->IDLE unconditionally after one cycle.
REQ-019 One-entry holding register; cmd_ready_o = (state!=FLUSH) && !flush_i && (holding empty || issuing this cycle).
REQ-020 A command accepted in cycle N drives in_valid_o at the earliest in cycle N+1, with operands_o taken from the holding register.
REQ-021 in_valid_o = holding full && (outstanding + fifo_count < DEPTH) && state!=FLUSH; operands_o stays stable while in_valid_o is high and in_ready_i is low.
REQ-022 An issue occurs on in_valid_o && in_ready_i and empties the holding register unless a new command is accepted in the same cycle.
REQ-023 out_ready_o = 1 in every state; the credit rule of REQ-021 guarantees FIFO space.
REQ-024 A capture (out_valid_i && out_ready_o) outside FLUSH pushes {result_i, status_i} into the FIFO.
REQ-025 The outstanding counter (clog2(DEPTH+1) bits) increments on issue and decrements on capture; it is unchanged when both occur in the same cycle.
REQ-026 A zero-latency unit, where issue and capture occur in the same cycle, is legal and needs no special handling.
REQ-027 rsp_valid_o = FIFO non-empty; rsp_result_o and rsp_status_o present the FIFO head in order; the FIFO pops on rsp_valid_o && rsp_ready_i.
REQ-028 A simultaneous push and pop leaves fifo_count unchanged, including at count 0 (new data visible the next cycle) and at count DEPTH-1.
REQ-029 A capture ORs status_i into fflags_o in the next cycle.
REQ-030 clear_flags_i zeroes fflags_o; if a capture occurs in the same cycle, fflags_o = status_i of that capture.
REQ-031 done_cnt_o increments on each capture outside FLUSH and wraps 0xFFFF->0x0000.
REQ-032 In FLUSH: flush_o=1, in_valid_o=0; the holding register, FIFO and outstanding counter are cleared; captures are discarded and do not update fflags_o or done_cnt_o.
REQ-033 Outside FLUSH, flush_o=0; fflags_o and done_cnt_o are not cleared by flush.
REQ-034 Behaviour on an out_valid_i that has no matching outstanding operation is undefined.

Reset
REQ-035 While rst_i is high at a clock edge, the next state is IDLE and the holding register, FIFO, outstanding counter, fflags_o and done_cnt_o are cleared.
REQ-036 Output values after reset: cmd_ready_o=1, in_valid_o=0, rsp_valid_o=0, flush_o=0, out_ready_o=1, fflags_o=0, done_cnt_o=0, operands_o=0.
REQ-037 Reset asserted mid-operation discards all in-flight work; no rsp_valid_o pulse follows reset.

Verification
REQ-038 Single op, unit model latency 2: cmd a=16'h3C00, b=16'h4000; model returns 16'h4000 with status 0 -> in_valid_o one cycle after accept, rsp_valid_o one cycle after capture, rsp_result_o=16'h4000, done_cnt_o=1.
REQ-039 Credit limit: in_ready_i=1, model withholds results, rsp_ready_i=0, 6 commands -> exactly 4 issues; in_valid_o stays 0 until a response is popped.
REQ-040 Zero-latency model (out_valid_i=in_valid_o && in_ready_i), 8 back-to-back commands, rsp_ready_i=1 -> 8 in-order responses, no bubbles after the first, outstanding count never exceeds 0 at cycle end.
REQ-041 Sticky flags: responses with status OF, then UF -> fflags_o has OF and UF set; clear_flags_i in the same cycle as an NX capture -> fflags_o = NX only.
REQ-042 Flush: 2 outstanding, 1 held, 1 in FIFO, then assert flush_i -> one-cycle flush_o=1, no further rsp_valid_o, state IDLE; a subsequent command completes normally.
REQ-043 Reset mid-run with 3 outstanding -> all outputs at reset values the next cycle; late out_valid_i responses are ignored.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Minimal subset of the FPnew package: formats, operations and status flags.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // Bit width of an operand in the given format.
    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:          return 32;
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            FP8:           return 8;
            default:       return 16;
        endcase
    endfunction

endpackage

// File: rtl/fphub_mult_issuer_if.sv
// Host command/response and multiply-unit request/response channels of the issuer.
interface fphub_mult_issuer_if #(
    parameter int unsigned WIDTH = 16
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [WIDTH-1:0]      cmd_a_i;
    logic [WIDTH-1:0]      cmd_b_i;

    logic [2:0][WIDTH-1:0] operands_o;
    logic                  in_valid_o;
    logic                  in_ready_i;

    logic [WIDTH-1:0]      result_i;
    fpnew_pkg::status_t    status_i;
    logic                  out_valid_i;
    logic                  out_ready_o;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [WIDTH-1:0]      rsp_result_o;
    fpnew_pkg::status_t    rsp_status_o;

    // Environment side: host plus multiply unit.
    modport master (
        output cmd_valid_i, cmd_a_i, cmd_b_i, in_ready_i,
        output result_i, status_i, out_valid_i, rsp_ready_i,
        input  cmd_ready_o, operands_o, in_valid_o, out_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_status_o
    );

    // Issuer side.
    modport slave (
        input  cmd_valid_i, cmd_a_i, cmd_b_i, in_ready_i,
        input  result_i, status_i, out_valid_i, rsp_ready_i,
        output cmd_ready_o, operands_o, in_valid_o, out_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_status_o
    );
endinterface

// File: rtl/fphub_mult_issuer.sv
// Issues HUB multiplies to an FPnew unit with credit-based flow control,
// buffers results in an in-order FIFO and tracks sticky flags and a done count.
module fphub_mult_issuer #(
    parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP16,
    parameter int unsigned           WIDTH    = fpnew_pkg::fp_width(FpFormat),
    parameter int unsigned           DEPTH    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fphub_mult_issuer_if.slave    bus,
    input  logic                  flush_i,
    input  logic                  clear_flags_i,
    output fpnew_pkg::operation_e op_o,
    output logic                  op_mod_o,
    output logic                  flush_o,
    output fpnew_pkg::status_t    fflags_o,
    output logic [15:0]           done_cnt_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        fpnew_pkg::status_t status;
    } entry_t;

    state_e             state_q, state_d;
    logic               hold_full_q;
    logic [WIDTH-1:0]   hold_a_q, hold_b_q;
    logic [CW-1:0]      outst_q, fifo_cnt_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    entry_t             fifo_q [DEPTH];
    fpnew_pkg::status_t fflags_q;
    logic [15:0]        done_cnt_q;

    logic               in_flush, in_valid, rsp_valid, cmd_ready;
    logic               cmd_acc, issue, capture, pop;
    logic [CW:0]        in_use;

    // Handshake decode; credits cover both in-flight ops and buffered results.
    assign in_flush  = (state_q == FLUSH);
    assign in_use    = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign in_valid  = hold_full_q && (in_use < DEPTH_V) && !in_flush;
    assign issue     = in_valid && bus.in_ready_i;
    assign cmd_ready = !in_flush && !flush_i && (!hold_full_q || issue);
    assign cmd_acc   = bus.cmd_valid_i && cmd_ready;
    // A response with nothing outstanding (e.g. stale after reset) is dropped.
    assign capture   = bus.out_valid_i && !in_flush && ((outst_q != '0) || issue);
    assign rsp_valid = (fifo_cnt_q != '0) && !in_flush;
    assign pop       = rsp_valid && bus.rsp_ready_i;

    // Output mapping.
    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.in_valid_o   = in_valid;
    assign bus.operands_o   = {hold_b_q, hold_a_q, WIDTH'(0)};
    assign bus.out_ready_o  = 1'b1;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_result_o = fifo_q[rd_ptr_q].result;
    assign bus.rsp_status_o = fifo_q[rd_ptr_q].status;
    assign op_o             = fpnew_pkg::MUL;
    assign op_mod_o         = 1'b0;
    assign flush_o          = in_flush;
    assign fflags_o         = fflags_q;
    assign done_cnt_o       = done_cnt_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a flush request overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_acc) state_d = RUN;
            RUN:   if (!hold_full_q && !cmd_acc && (outst_q == '0) && (fifo_cnt_q == '0))
                       state_d = IDLE;
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = FLUSH;
    end

    // Holding register, outstanding counter and FIFO pointers; all dropped on flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || in_flush) begin
            hold_full_q <= 1'b0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            if (cmd_acc) begin
                hold_full_q <= 1'b1;
                hold_a_q    <= bus.cmd_a_i;
                hold_b_q    <= bus.cmd_b_i;
            end else if (issue) begin
                hold_full_q <= 1'b0;
            end
            outst_q    <= outst_q + CW'(issue) - CW'(capture);
            fifo_cnt_q <= fifo_cnt_q + CW'(capture) - CW'(pop);
            if (capture) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Result storage; contents are only meaningful below fifo_cnt_q.
    always_ff @(posedge clk_i) begin
        if (capture) fifo_q[wr_ptr_q] <= '{result: bus.result_i, status: bus.status_i};
    end

    // Sticky flags and completion counter survive flush, not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            if (clear_flags_i)
                fflags_q <= capture ? bus.status_i : '0;
            else if (capture)
                fflags_q <= fpnew_pkg::status_t'(fflags_q | bus.status_i);
            if (capture) done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fphub_mult_issuer.sv
// Scoreboard bench for fphub_mult_issuer with a behavioural multiply-unit model.
module tb_fphub_mult_issuer;
    localparam int unsigned W   = 16;
    localparam int unsigned LAT = 2;
    localparam int unsigned TMO = 200;

    typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; logic [4:0] st; } cmd_t;
    typedef struct packed { logic [W-1:0] res; logic [4:0] st; } rsp_t;
    typedef struct packed { logic [31:0] due; logic [W-1:0] res; logic [4:0] st; } pend_t;

    logic clk = 1'b0;
    logic rst, flush_i, clr_man, clr_on_cap, clear_flags, zl, hold_rsp, uv, bg_done;
    logic [W-1:0] ur;
    logic [4:0]   us;
    fpnew_pkg::operation_e op;
    logic                  op_mod, flush_o;
    fpnew_pkg::status_t    fflags;
    logic [15:0]           done_cnt;

    int unsigned cyc, n_chk, n_fail;
    int unsigned acc_cyc, issue_cyc, cap_cyc, rsp_first, rsp_last;
    int unsigned n_issue, n_rsp, n_flush_cyc, n_unexp, n_bad_issue, n_outst_bad;
    logic chk_outst;

    cmd_t  script[$];
    rsp_t  sb[$];
    pend_t pend[$];

    fphub_mult_issuer_if #(.WIDTH(W)) bus ();

    assign bus.out_valid_i = zl ? (bus.in_valid_o & bus.in_ready_i) : uv;
    assign bus.result_i    = ur;
    assign bus.status_i    = us;
    assign clear_flags     = clr_on_cap ? bus.out_valid_i : clr_man;

    fphub_mult_issuer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .flush_i       (flush_i),
        .clear_flags_i (clear_flags),
        .op_o          (op),
        .op_mod_o      (op_mod),
        .flush_o       (flush_o),
        .fflags_o      (fflags),
        .done_cnt_o    (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Unit model: delivers pending results after LAT cycles, or in zero-latency mode
    // presents the head of the script combinationally with the issue.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (flush_o) begin
            pend.delete();
            uv = 1'b0;
        end else begin
            if (uv && !zl && pend.size() > 0) void'(pend.pop_front());
            if (zl) begin
                uv = 1'b0;
                if (script.size() > 0) begin
                    ur = script[0].res;
                    us = script[0].st;
                end
            end else if (!hold_rsp && pend.size() > 0 && pend[0].due <= cyc) begin
                uv = 1'b1;
                ur = pend[0].res;
                us = pend[0].st;
            end else begin
                uv = 1'b0;
            end
        end
    end

    // Monitor: checks issued operands and pops the scoreboard on each response.
    always @(negedge clk) begin : mon
        cmd_t  c;
        rsp_t  e;
        pend_t p;
        if (!rst) begin
            if (bus.cmd_valid_i && bus.cmd_ready_o) acc_cyc = cyc;
            if (bus.in_valid_o && bus.in_ready_i) begin
                n_issue++;
                issue_cyc = cyc;
                if (script.size() == 0) begin
                    n_bad_issue++;
                end else begin
                    c = script.pop_front();
                    check("issue_operands", 64'(bus.operands_o), {16'h0, c.b, c.a, 16'h0});
                    if (!zl) begin
                        p.due = cyc + LAT;
                        p.res = c.res;
                        p.st  = c.st;
                        pend.push_back(p);
                    end
                end
            end
            if (bus.out_valid_i && !flush_o) cap_cyc = cyc;
            if (bus.rsp_valid_o) begin
                if (sb.size() == 0) begin
                    n_unexp++;
                end else if (bus.rsp_ready_i) begin
                    e = sb.pop_front();
                    check("rsp_result", 64'(bus.rsp_result_o), 64'(e.res));
                    check("rsp_status", 64'(bus.rsp_status_o), 64'(e.st));
                    n_rsp++;
                    if (n_rsp == 1) rsp_first = cyc;
                    rsp_last = cyc;
                end
            end
            if (flush_o) n_flush_cyc++;
            if (chk_outst && dut.outst_q != '0) n_outst_bad++;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic [4:0] st);
        cmd_t c;
        rsp_t r;
        int unsigned k;
        c.a = a; c.b = b; c.res = res; c.st = st;
        r.res = res; r.st = st;
        script.push_back(c);
        sb.push_back(r);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_a_i     = a;
        bus.cmd_b_i     = b;
        for (k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (bus.cmd_ready_o) break;
            tick();
        end
        tick();
        bus.cmd_valid_i = 1'b0;
        check("send_accept", 64'(k < TMO), 64'd1);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned k;
        for (k = 0; k < budget; k++) begin
            if (sb.size() == 0 && script.size() == 0 && pend.size() == 0 && !bus.rsp_valid_o) break;
            tick();
        end
        check(name, 64'(k < budget), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'd1);
        check({tag, "_in_valid"},  64'(bus.in_valid_o),  64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check({tag, "_flush_o"},   64'(flush_o),         64'd0);
        check({tag, "_out_ready"}, 64'(bus.out_ready_o), 64'd1);
        check({tag, "_fflags"},    64'(fflags),          64'd0);
        check({tag, "_done_cnt"},  64'(done_cnt),        64'd0);
        check({tag, "_operands"},  64'(bus.operands_o),  64'd0);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; clr_man = 1'b0; clr_on_cap = 1'b0; zl = 1'b0;
        hold_rsp = 1'b0; uv = 1'b0; ur = '0; us = '0; bg_done = 1'b0; chk_outst = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_a_i = '0; bus.cmd_b_i = '0;
        bus.in_ready_i = 1'b1; bus.rsp_ready_i = 1'b1;
        cyc = 0; n_chk = 0; n_fail = 0; n_issue = 0; n_rsp = 0; n_flush_cyc = 0;
        n_unexp = 0; n_bad_issue = 0; n_outst_bad = 0;
        acc_cyc = 0; issue_cyc = 0; cap_cyc = 0; rsp_first = 0; rsp_last = 0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("op_o", 64'(op), 64'(fpnew_pkg::MUL));
        check("op_mod_o", 64'(op_mod), 64'd0);
        tick();

        // Single multiply through a latency-2 unit.
        n_rsp = 0;
        send(16'h3C00, 16'h4000, 16'h4000, 5'b00000);
        wait_drain("p1_drain", 40);
        check("p1_issue_latency", 64'(issue_cyc - acc_cyc), 64'd1);
        check("p1_rsp_latency", 64'(rsp_first - cap_cyc), 64'd1);
        check("p1_done_cnt", 64'(done_cnt), 64'd1);

        // Credit limit: results withheld and not popped.
        hold_rsp = 1'b1; bus.rsp_ready_i = 1'b0; n_issue = 0; n_rsp = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h5000 + 16'(i), 5'b00000);
                bg_done = 1'b1;
            end
        join_none
        repeat (20) tick();
        check("p2_issue_count_withheld", 64'(n_issue), 64'd4);
        @(negedge clk);
        check("p2_in_valid_withheld", 64'(bus.in_valid_o), 64'd0);
        tick();
        hold_rsp = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("p2_in_valid_fifo_full", 64'(bus.in_valid_o), 64'd0);
        check("p2_issue_count_fifo_full", 64'(n_issue), 64'd4);
        tick();
        bus.rsp_ready_i = 1'b1;
        for (int k = 0; k < TMO && !bg_done; k++) tick();
        check("p2_all_accepted", 64'(bg_done), 64'd1);
        wait_drain("p2_drain", 60);
        check("p2_issue_count_final", 64'(n_issue), 64'd6);
        check("p2_rsp_count", 64'(n_rsp), 64'd6);
        check("p2_done_cnt", 64'(done_cnt), 64'd7);

        // Zero-latency unit, back-to-back commands.
        zl = 1'b1; n_rsp = 0; n_outst_bad = 0; chk_outst = 1'b1;
        for (int i = 0; i < 8; i++)
            send(16'h3000 + 16'(i), 16'h3800 + 16'(i), 16'h6000 + 16'(i), 5'b00000);
        wait_drain("p3_drain", 40);
        chk_outst = 1'b0;
        zl = 1'b0;
        check("p3_rsp_count", 64'(n_rsp), 64'd8);
        check("p3_no_bubbles", 64'(rsp_last - rsp_first), 64'd7);
        check("p3_outstanding_zero", 64'(n_outst_bad), 64'd0);
        check("p3_done_cnt", 64'(done_cnt), 64'd15);

        // Sticky flags, then clear coinciding with a capture.
        clr_man = 1'b1;
        tick();
        clr_man = 1'b0;
        send(16'h7000, 16'h7000, 16'h7C00, 5'b00100);
        send(16'h0400, 16'h0400, 16'h0000, 5'b00010);
        wait_drain("p4_drain_a", 40);
        check("p4_flags_of_uf", 64'(fflags), 64'h06);
        clr_on_cap = 1'b1;
        send(16'h3C01, 16'h3C01, 16'h3C02, 5'b00001);
        wait_drain("p4_drain_b", 40);
        clr_on_cap = 1'b0;
        check("p4_flags_clear_nx", 64'(fflags), 64'h01);
        check("p4_done_cnt", 64'(done_cnt), 64'd18);

        // Flush with work in every stage.
        bus.rsp_ready_i = 1'b0;
        send(16'h4000, 16'h4000, 16'h4400, 5'b00000);
        repeat (6) tick();
        hold_rsp = 1'b1;
        send(16'h4100, 16'h4000, 16'h4500, 5'b00000);
        send(16'h4200, 16'h4000, 16'h4600, 5'b00000);
        repeat (2) tick();
        bus.in_ready_i = 1'b0;
        send(16'h4300, 16'h4000, 16'h4700, 5'b00000);
        repeat (2) tick();
        check("p5_done_before_flush", 64'(done_cnt), 64'd19);
        n_flush_cyc = 0;
        flush_i = 1'b1;
        @(negedge clk);
        check("p5_cmd_ready_on_flush_req", 64'(bus.cmd_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        sb.delete();
        script.delete();
        @(negedge clk);
        check("p5_flush_o_high", 64'(flush_o), 64'd1);
        check("p5_in_valid_in_flush", 64'(bus.in_valid_o), 64'd0);
        check("p5_rsp_valid_in_flush", 64'(bus.rsp_valid_o), 64'd0);
        tick();
        @(negedge clk);
        check("p5_flush_o_low", 64'(flush_o), 64'd0);
        check("p5_cmd_ready_after", 64'(bus.cmd_ready_o), 64'd1);
        check("p5_in_valid_after", 64'(bus.in_valid_o), 64'd0);
        tick();
        bus.in_ready_i = 1'b1; hold_rsp = 1'b0; bus.rsp_ready_i = 1'b1;
        repeat (5) tick();
        check("p5_flush_cycles", 64'(n_flush_cyc), 64'd1);
        check("p5_no_rsp_after_flush", 64'(n_unexp), 64'd0);
        check("p5_done_after_flush", 64'(done_cnt), 64'd19);
        send(16'h3C00, 16'h3C00, 16'h3C00, 5'b00000);
        wait_drain("p5_drain_after", 40);
        check("p5_done_final", 64'(done_cnt), 64'd20);

        // Reset with three operations in flight; late responses must be ignored.
        hold_rsp = 1'b1;
        for (int i = 0; i < 3; i++)
            send(16'h5000 + 16'(i), 16'h5100, 16'h8000 + 16'(i), 5'b00100);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        script.delete();
        @(negedge clk);
        check_reset_outputs("p6");
        tick();
        hold_rsp = 1'b0;
        repeat (8) tick();
        wait_drain("p6_drain", 20);
        check("p6_done_ignores_late", 64'(done_cnt), 64'd0);
        check("p6_flags_ignore_late", 64'(fflags), 64'd0);
        check("p6_no_unexpected_rsp", 64'(n_unexp), 64'd0);
        check("unscripted_issues", 64'(n_bad_issue), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
